// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared widths, FSM state type and host burst-length clamp for the data memory arbiter
package data_mem_arb_pkg;
   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 64;
   localparam int LEN_W          = 5;
   localparam int MAX_BURST      = 16;
   localparam int MAX_CPU_STREAK = 4;
   localparam int STREAK_W       = $clog2(MAX_CPU_STREAK + 1);
   typedef enum logic {IDLE, HOST_BURST} state_e;
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return len == '0 ? LEN_W'(1) : len > LEN_W'(MAX_BURST) ? LEN_W'(MAX_BURST) : len;
   endfunction
endpackage

// File: rtl/dm_burst_ctr.sv
// dm_burst_ctr: latches a host burst's start/length and walks the wrapping beat address
module dm_burst_ctr
   import data_mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] addr,
   output logic              last_beat
);
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
   always_comb begin
      base_d = load ? start_addr : base_q;
      len_d  = load ? len : len_q;
      idx_d  = load ? LEN_W'(1) : adv ? idx_q + 1'b1 : idx_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end
   // beat 0 is issued at grant, so the counter starts at 1 once loaded
   assign addr      = base_q + ADDR_W'(idx_q);
   assign last_beat = idx_q == len_q - 1'b1;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between CPU single beats and host bursts
module data_mem_arbiter
   import data_mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [LEN_W-1:0]  host_len,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_wready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_en,
   output logic              mem_read_en,
   input  logic [DATA_W-1:0] mem_data_out
);
   state_e              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                burst_we_q, burst_we_d, cpu_rv_q, cpu_rv_d, host_rv_q, host_rv_d, done_q, done_d;
   logic [LEN_W-1:0]    len_c;
   logic [ADDR_W-1:0]   beat_addr;
   logic                idle, burst, cpu_win, host_win, last_beat;
   assign len_c    = clamp_len(host_len);
   assign idle     = rst && state_q == IDLE;
   assign burst    = rst && state_q == HOST_BURST;
   assign cpu_win  = idle && cpu_req && (!host_req || streak_q < STREAK_W'(MAX_CPU_STREAK));
   assign host_win = idle && host_req && !cpu_win;
   dm_burst_ctr u_ctr (
      .clk        (clk),
      .rst        (rst),
      .load       (host_win),
      .adv        (burst),
      .start_addr (host_addr),
      .len        (len_c),
      .addr       (beat_addr),
      .last_beat  (last_beat)
   );
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end
   always_comb begin
      state_d = state_q == IDLE ? (host_win && len_c != LEN_W'(1) ? HOST_BURST : IDLE)
                                : (last_beat ? IDLE : HOST_BURST);
   end
   always_comb begin
      streak_d   = (!host_req || host_win) ? '0
                 : (cpu_win && streak_q < STREAK_W'(MAX_CPU_STREAK)) ? streak_q + 1'b1 : streak_q;
      burst_we_d = host_win ? host_we : burst_we_q;
      cpu_rv_d   = cpu_win && !cpu_we;
      host_rv_d  = (host_win && !host_we) || (burst && !burst_we_q);
      done_d     = (host_win && len_c == LEN_W'(1)) || (burst && last_beat);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         streak_q   <= '0;
         burst_we_q <= 1'b0;
         cpu_rv_q   <= 1'b0;
         host_rv_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         streak_q   <= streak_d;
         burst_we_q <= burst_we_d;
         cpu_rv_q   <= cpu_rv_d;
         host_rv_q  <= host_rv_d;
         done_q     <= done_d;
      end
   end
   // every output is gated by rst so the memory sees no enables while held in reset
   always_comb begin
      cpu_gnt      = cpu_win;
      host_gnt     = host_win;
      host_wready  = (host_win && host_we) || (burst && burst_we_q);
      mem_address  = cpu_win ? cpu_addr : host_win ? host_addr : burst ? beat_addr : '0;
      mem_write_en = (cpu_win && cpu_we) || host_wready;
      mem_read_en  = (cpu_win && !cpu_we) || host_rv_d;
      mem_data_in  = cpu_win ? cpu_wdata : host_wready ? host_wdata : '0;
      cpu_rvalid   = rst && cpu_rv_q;
      host_rvalid  = rst && host_rv_q;
      host_done    = rst && done_q;
      cpu_rdata    = cpu_rvalid ? mem_data_out : '0;
      host_rdata   = host_rvalid ? mem_data_out : '0;
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench with a behavioural memory behind the arbiter
module tb_data_mem_arbiter;
   import data_mem_arb_pkg::*;
   logic              clk = 1'b0, rst = 1'b0;
   logic              cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0, host_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0, host_wdata = '0;
   logic [LEN_W-1:0]  host_len = '0;
   logic              cpu_gnt, cpu_rvalid, host_gnt, host_wready, host_rvalid, host_done;
   logic              mem_write_en, mem_read_en;
   logic [DATA_W-1:0] cpu_rdata, host_rdata, mem_data_in, mem_data_out;
   logic [ADDR_W-1:0] mem_address;
   wire  [7:0]        flags = {cpu_gnt, cpu_rvalid, host_gnt, host_wready, host_rvalid, host_done, mem_write_en, mem_read_en};
   always #5 clk = ~clk;
   data_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_wready(host_wready),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_done(host_done),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
      .mem_read_en(mem_read_en), .mem_data_out(mem_data_out)
   );
   logic [63:0] mem [256];
   logic        mem_ok = 1'b0;
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int i = 0; i < 256; i++) mem[i] <= 64'(i + 1);
         mem_ok <= 1'b1;
      end else if (mem_write_en) mem[mem_address] <= mem_data_in;
      if (mem_read_en) mem_data_out <= mem[mem_address];
   end
   typedef struct {int c; logic [63:0] d;} exp_t;
   exp_t        cq[$], hq[$];
   exp_t        ce, he;
   logic [63:0] exp_mem [256];
   int          cyc_n = 0, n_vec = 0, n_err = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask
   always @(negedge clk) begin
      if (cpu_rvalid) begin
         if (cq.size() == 0) chk("cpu_rvalid_spurious", 1, 0);
         else begin
            ce = cq.pop_front();
            chk("cpu_rv_cycle", cyc_n, ce.c);
            chk("cpu_rdata", cpu_rdata, ce.d);
         end
      end
      if (host_rvalid) begin
         if (hq.size() == 0) chk("host_rvalid_spurious", 1, 0);
         else begin
            he = hq.pop_front();
            chk("host_rv_cycle", cyc_n, he.c);
            chk("host_rdata", host_rdata, he.d);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_op(input logic we, input logic [7:0] a, input logic [63:0] wd);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      @(negedge clk);
      chk("cpu_gnt", cpu_gnt, 1);
      chk("cpu_mem_addr", mem_address, a);
      chk("cpu_en", {mem_write_en, mem_read_en}, we ? 2'b10 : 2'b01);
      if (we) begin
         chk("cpu_mem_din", mem_data_in, wd);
         exp_mem[a] = wd;
      end else cq.push_back('{cyc_n + 1, exp_mem[a]});
      tick();
      cpu_req = 1'b0;
   endtask
   task automatic host_burst(input logic we, input logic [7:0] a, input logic [4:0] len, input int n);
      logic [7:0] ba;
      host_req = 1'b1; host_we = we; host_addr = a; host_len = len;
      for (int i = 0; i < n; i++) begin
         ba = a + 8'(i);
         host_wdata = 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(ba);
         @(negedge clk);
         chk("host_gnt", host_gnt, i == 0);
         chk("host_beat_addr", mem_address, ba);
         chk("host_en", {mem_write_en, mem_read_en}, we ? 2'b10 : 2'b01);
         chk("host_wready", host_wready, we);
         if (i > 0) chk("host_done_early", host_done, 0);
         if (we) begin
            chk("host_mem_din", mem_data_in, host_wdata);
            exp_mem[ba] = host_wdata;
         end else hq.push_back('{cyc_n + 1, exp_mem[ba]});
         tick();
         host_req = 1'b0;
      end
      @(negedge clk);
      chk("host_done", host_done, 1);
      chk("host_last_rvalid", host_rvalid, !we);
      chk("host_idle_after", {mem_write_en, mem_read_en}, 0);
      tick();
   endtask
   initial begin
      int st, rem, bi;
      for (int i = 0; i < 256; i++) exp_mem[i] = 64'(i + 1);
      cpu_req = 1'b1; host_req = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_flags", flags, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_din", mem_data_in, 0);
      tick();
      cpu_req = 1'b0; host_req = 1'b0; rst = 1'b1;
      tick();
      cpu_op(1'b0, 8'd3, 64'd0);
      cpu_op(1'b1, 8'd40, 64'hDEADBEEF);
      cpu_op(1'b0, 8'd40, 64'd0);
      tick();
      host_burst(1'b0, 8'd254, 5'd4, 4);
      host_burst(1'b1, 8'd32, 5'd0, 1);
      host_burst(1'b1, 8'd32, 5'd20, 16);
      cpu_op(1'b0, 8'd47, 64'd0);
      cpu_op(1'b0, 8'd32, 64'd0);
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'd10; host_len = 5'd3;
      st = 0; rem = 0; bi = 0;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         if (rem > 0) begin
            chk("pat_cpu_gnt_burst", cpu_gnt, 0);
            chk("pat_host_gnt_burst", host_gnt, 0);
            chk("pat_beat_addr", mem_address, 8'(10 + bi));
            hq.push_back('{cyc_n + 1, exp_mem[10 + bi]});
            bi++; rem--;
         end else if (st < 4) begin
            chk("pat_cpu_gnt", cpu_gnt, 1);
            chk("pat_host_gnt_cpu", host_gnt, 0);
            cq.push_back('{cyc_n + 1, exp_mem[5]});
            st++;
         end else begin
            chk("pat_cpu_gnt_host", cpu_gnt, 0);
            chk("pat_host_gnt", host_gnt, 1);
            chk("pat_host_addr", mem_address, 10);
            hq.push_back('{cyc_n + 1, exp_mem[10]});
            st = 0; rem = 2; bi = 1;
         end
         tick();
      end
      cpu_req = 1'b0; host_req = 1'b0;
      tick(); tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'd100; host_len = 5'd8;
      @(negedge clk);
      chk("rstb_gnt", host_gnt, 1);
      hq.push_back('{cyc_n + 1, exp_mem[100]});
      tick();
      host_req = 1'b0;
      @(negedge clk);
      chk("rstb_beat1", mem_address, 101);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rstb_flags", flags, 0);
      chk("rstb_addr", mem_address, 0);
      tick();
      @(negedge clk);
      chk("rstb_flags_held", flags, 0);
      tick();
      rst = 1'b1;
      cpu_op(1'b0, 8'd0, 64'd0);
      tick(); tick();
      chk("cpu_queue_drained", cq.size(), 0);
      chk("host_queue_drained", hq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
